// File: rtl/digit_shuffler.sv
// digit_shuffler: produces a random permutation of the digits 1..9 on nine
// parallel 4-bit outputs. A 16-bit Galois LFSR drives an 8-step Fisher-Yates
// shuffle, one step per clock, and the finished permutation is published on
// the last step's edge, so the outputs only ever show complete permutations.
module digit_shuffler #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic [3:0]  num5,
  output logic [3:0]  num6,
  output logic [3:0]  num7,
  output logic [3:0]  num8,
  output logic [3:0]  num9
);

  localparam int NUM_LANES = 9;

  // Slot k holds digit k+1.
  localparam logic [NUM_LANES-1:0][3:0] IDENT = {
    4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1
  };

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DONE} state_t;

  state_t                       state;
  logic [NUM_LANES-1:0][3:0]    arr;
  logic [NUM_LANES-1:0][3:0]    arr_nxt;
  logic [NUM_LANES-1:0][3:0]    nums;
  logic [3:0]                   idx;
  logic [15:0]                  lfsr;
  logic [15:0]                  lfsr_nxt;
  logic [7:0]                   prod;
  logic [3:0]                   j;
  logic [3:0]                   arr_j;
  logic [3:0]                   arr_idx;

  // Scale the 4-bit random nibble into 0..idx. Taking bits [7:4] of
  // r*(idx+1) is floor(r*(idx+1)/16), which is at most idx because r <= 15.
  assign prod = {4'd0, lfsr[3:0]} * ({4'd0, idx} + 8'd1);
  assign j    = prod[7:4];

  // One right shift of the Galois LFSR, folding the feedback mask in on a 1.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

  // Read out the two slots taking part in this step's swap.
  always_comb begin
    arr_j   = 4'd0;
    arr_idx = 4'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (j == 4'(k))   arr_j   = arr[k];
      if (idx == 4'(k)) arr_idx = arr[k];
    end
  end

  // Swap slots idx and j. When j==idx the first branch writes the slot's own
  // value back, so the array is unchanged.
  always_comb begin
    arr_nxt = arr;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (idx == 4'(k))    arr_nxt[k] = arr_j;
      else if (j == 4'(k)) arr_nxt[k] = arr_idx;
    end
  end

  // Control FSM, which also holds the shuffle state and the registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      lfsr  <= SEED;
      idx   <= 4'd0;
      arr   <= IDENT;
      nums  <= IDENT;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
            valid <= 1'b0;
            // An all-zero seed would lock the LFSR, so zero falls back to SEED.
            if (seed_load) lfsr <= (seed == 16'h0000) ? SEED : seed;
          end
        end
        INIT: begin
          arr   <= IDENT;
          idx   <= 4'd8;
          state <= SHUFFLE;
        end
        SHUFFLE: begin
          arr  <= arr_nxt;
          lfsr <= lfsr_nxt;
          if (idx == 4'd1) begin
            // Publish the array including this final swap.
            nums  <= arr_nxt;
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            idx <= idx - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign num1 = nums[0];
  assign num2 = nums[1];
  assign num3 = nums[2];
  assign num4 = nums[3];
  assign num5 = nums[4];
  assign num6 = nums[5];
  assign num7 = nums[6];
  assign num8 = nums[7];
  assign num9 = nums[8];

endmodule
